pattern_pwm_seq: RTL

PATTERN_PWM_SEQ -- requirements
Module: pattern_pwm_seq

---
 rtl/pattern_pwm_pkg.sv | 14 +
 rtl/pwm_bit_timer.sv | 39 +++
 rtl/pattern_pwm_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pattern_pwm_pkg.sv
// Shared types and default sizes for the pattern PWM sequencer.
package pattern_pwm_pkg;

    localparam int PAT_W_DEF = 16;
    localparam int DIV_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_bit_timer.sv
// Bit-period timer: counts max(div,1) cycles per bit and raises bit_tick on
// the last cycle of every bit period while enabled.
module pwm_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             bit_tick
);

    logic [DIV_W-1:0] div_m1;
    logic [DIV_W-1:0] reload;
    logic [DIV_W-1:0] cnt;

    // A divider of zero behaves like one: the counter reloads with zero.
    assign div_m1 = (div == '0) ? '0 : div - DIV_W'(1);

    // Down-counter, reloaded from the period latched at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload <= '0;
            cnt    <= '0;
        end else if (load) begin
            reload <= div_m1;
            cnt    <= div_m1;
        end else if (clear) begin
            cnt    <= '0;
        end else if (enable) begin
            cnt    <= (cnt == '0) ? reload : cnt - DIV_W'(1);
        end
    end

    assign bit_tick = enable && (cnt == '0);

endmodule

// File: rtl/pattern_pwm_seq.sv
// Pattern PWM sequencer: shifts out a latched bit pattern, each bit held for
// a programmable number of clocks, then pulses valid for one cycle.
// Optional feature macro PATTERN_PWM_REPEAT_EN adds rep_cnt (passes = rep_cnt+1).
// Handshake: pwm_en is a start request accepted only in IDLE with abort low;
// there is no ready, requests outside IDLE are dropped, and valid is a single
// cycle completion strobe with no backpressure.
module pattern_pwm_seq
    import pattern_pwm_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_en,
    input  logic [PAT_W-1:0] PAT,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [DIV_W-1:0] bit_div,
    input  logic             msb_first,
    input  logic             idle_level,
    input  logic             abort,
`ifdef PATTERN_PWM_REPEAT_EN
    input  logic [CNT_W-1:0] rep_cnt,
`endif
    output logic             pwm_out,
    output logic             busy,
    output logic             valid,
    output logic [1:0]       state_dbg
);

    state_t           state, state_nxt;
    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic             msb_r;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] idx_adv;
    logic [LEN_W-1:0] len_eff;
    logic             bit_tick;
    logic             last_bit;
    logic             last_pass;
    logic             start, kill, finish, advance;
    logic             pwm_nxt, busy_nxt, valid_nxt;

    // Picks sequence bit k out of pattern p of length l in the requested order.
    function automatic logic pick_bit(input logic [PAT_W-1:0] p,
                                      input logic [LEN_W-1:0] l,
                                      input logic             m,
                                      input logic [LEN_W-1:0] k);
        logic [LEN_W-1:0] pos;
        logic [PAT_W-1:0] sh;
        pos = m ? (l - LEN_W'(1) - k) : k;
        sh  = p >> pos;
        return |(sh & PAT_W'(1));
    endfunction

    assign len_eff  = (pat_len == '0 || pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
    assign last_bit = (idx == len_r - LEN_W'(1));
    assign idx_adv  = last_bit ? '0 : idx + LEN_W'(1);
    assign state_dbg = state;

`ifdef PATTERN_PWM_REPEAT_EN
    logic [CNT_W-1:0] rep_r;
    logic [CNT_W-1:0] pass_r;

    assign last_pass = (pass_r == rep_r);

    // Pass counter; passes run back to back with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_r  <= '0;
            pass_r <= '0;
        end else if (start) begin
            rep_r  <= rep_cnt;
            pass_r <= '0;
        end else if (kill) begin
            pass_r <= '0;
        end else if (advance && last_bit) begin
            pass_r <= pass_r + CNT_W'(1);
        end
    end
`else
    assign last_pass = 1'b1;
`endif

    pwm_bit_timer #(.DIV_W(DIV_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .clear    (kill),
        .enable   (state == ST_RUN),
        .div      (bit_div),
        .bit_tick (bit_tick)
    );

    // Next state and next registered outputs; abort wins over a final tick.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        kill      = 1'b0;
        finish    = 1'b0;
        advance   = 1'b0;
        pwm_nxt   = idle_level;
        busy_nxt  = 1'b0;
        valid_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pwm_en && !abort) begin
                    state_nxt = ST_RUN;
                    start     = 1'b1;
                    pwm_nxt   = pick_bit(PAT, len_eff, msb_first, '0);
                    busy_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    kill      = 1'b1;
                end else if (bit_tick && last_bit && last_pass) begin
                    state_nxt = ST_DONE;
                    finish    = 1'b1;
                    valid_nxt = 1'b1;
                end else if (bit_tick) begin
                    advance   = 1'b1;
                    pwm_nxt   = pick_bit(pat_r, len_r, msb_r, idx_adv);
                    busy_nxt  = 1'b1;
                end else begin
                    pwm_nxt   = pwm_out;
                    busy_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pwm_out <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            state   <= state_nxt;
            pwm_out <= pwm_nxt;
            busy    <= busy_nxt;
            valid   <= valid_nxt;
        end
    end

    // Configuration latched at start and the bit index within a pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r <= '0;
            len_r <= '0;
            msb_r <= 1'b0;
            idx   <= '0;
        end else if (start) begin
            pat_r <= PAT;
            len_r <= len_eff;
            msb_r <= msb_first;
            idx   <= '0;
        end else if (kill) begin
            idx   <= '0;
        end else if (advance) begin
            idx   <= idx_adv;
        end
    end

endmodule
